// File: rtl/nr_iter_engine.sv
// Newton-Raphson sequencer: holds N estimates, trades them for a step with an external solve unit, applies x <= sat(x - delta).
// Latency: >=3 cycles per iteration (REQ, WAIT, UPD); iter=0 reaches DONE on the second edge after start is sampled.
// Backpressure: eval_req/eval_x hold in REQ until eval_ready; WAIT blocks until the delta_valid pulse.
//
// Ports: clk/rst (async active-high) | start, x0, iter: run request | eval_req, eval_ready, eval_x: estimate out
//        delta_valid, eval_delta: step in | xn, iterCount: result | busy, rootsFound, overflow (sticky saturation flag)
// Optional feature: define NR_CONV_CHECK_EN to stop early once every |delta_i| <= TOL.
module nr_iter_engine #(
    parameter int              DW  = 32,
    parameter int              FW  = 24,
    parameter int              N   = 3,
    parameter int              IW  = 4,
    parameter logic [DW-1:0]   TOL = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*DW-1:0]   x0,
    input  logic [IW-1:0]     iter,
    output logic              eval_req,
    input  logic              eval_ready,
    output logic [N*DW-1:0]   eval_x,
    input  logic              delta_valid,
    input  logic [N*DW-1:0]   eval_delta,
    output logic [N*DW-1:0]   xn,
    output logic [IW-1:0]     iterCount,
    output logic              busy,
    output logic              rootsFound,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_WAIT, S_UPD, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     limit;
    logic [N*DW-1:0]   delta_q;
    logic [N*DW-1:0]   x_sat;
    logic [N-1:0]      sat_hit;
    logic [IW-1:0]     iter_inc;
    logic              last_iter;
    logic              conv;
    logic [DW:0]       diff;

    assign iter_inc  = iterCount + IW'(1);
    assign last_iter = (iter_inc == limit);

    // xn is only rewritten in UPD or on start, so it is already stable while eval_req is high.
    assign eval_x = xn;

    // Subtract in DW+1 bits; a mismatch between the two top bits means the true result left the DW range.
    always_comb begin
        x_sat   = '0;
        sat_hit = '0;
        diff    = '0;
        for (int i = 0; i < N; i++) begin
            diff = {xn[i*DW+DW-1], xn[i*DW +: DW]} - {delta_q[i*DW+DW-1], delta_q[i*DW +: DW]};
            if (diff[DW] != diff[DW-1]) begin
                sat_hit[i]        = 1'b1;
                x_sat[i*DW +: DW] = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else begin
                x_sat[i*DW +: DW] = diff[DW-1:0];
            end
        end
    end

`ifdef NR_CONV_CHECK_EN
    logic [N-1:0]  small;
    logic [DW-1:0] mag;

    // Unsigned magnitude: the most negative step maps to 2^(DW-1), which is always above TOL.
    always_comb begin
        small = '0;
        mag   = '0;
        for (int i = 0; i < N; i++) begin
            mag      = delta_q[i*DW+DW-1] ? (~delta_q[i*DW +: DW] + DW'(1)) : delta_q[i*DW +: DW];
            small[i] = (mag <= TOL);
        end
    end
    assign conv = &small;
`else
    assign conv = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        eval_req   = 1'b0;
        busy       = 1'b0;
        rootsFound = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = (limit == '0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                busy     = 1'b1;
                eval_req = 1'b1;
                if (eval_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (delta_valid) state_nxt = S_UPD;
            end
            S_UPD: begin
                busy      = 1'b1;
                state_nxt = (last_iter || conv) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                rootsFound = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xn        <= '0;
            iterCount <= '0;
            overflow  <= 1'b0;
            limit     <= '0;
            delta_q   <= '0;
        end else begin
            if ((state == S_IDLE || state == S_DONE) && start) begin
                xn        <= x0;
                limit     <= iter;
                iterCount <= '0;
                overflow  <= 1'b0;
            end
            if (state == S_WAIT && delta_valid) begin
                delta_q <= eval_delta;
            end
            if (state == S_UPD) begin
                xn        <= x_sat;
                iterCount <= iter_inc;
                if (|sat_hit) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nr_iter_engine.sv
module tb_nr_iter_engine;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int IW = 4;

    localparam logic [95:0] X123   = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000};
    localparam logic [95:0] D25    = {3{32'h0040_0000}};
    localparam logic [95:0] X_ONES = {3{32'h0100_0000}};

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [95:0]     x0;
    logic [IW-1:0]   iter;
    logic            eval_req;
    logic            eval_ready;
    logic [95:0]     eval_x;
    logic            delta_valid;
    logic [95:0]     eval_delta;
    logic [95:0]     xn;
    logic [IW-1:0]   iterCount;
    logic            busy;
    logic            rootsFound;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int req_cycles = 0;

    nr_iter_engine #(.DW(DW), .FW(24), .N(N), .IW(IW), .TOL(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .iter(iter),
        .eval_req(eval_req), .eval_ready(eval_ready), .eval_x(eval_x),
        .delta_valid(delta_valid), .eval_delta(eval_delta),
        .xn(xn), .iterCount(iterCount), .busy(busy),
        .rootsFound(rootsFound), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eval_req && eval_ready) xfers++;
        if (eval_req) req_cycles++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a run and act as the evaluation unit until rootsFound or the cycle budget runs out.
    task automatic run_nr(input logic [95:0] x0_v, input logic [IW-1:0] iter_v, input logic [95:0] d_v,
                          input bit geo, input int stall, output int n_xfer);
        int x_start;
        int k;
        int budget;
        logic [95:0] held;
        x_start = xfers;
        k       = 0;
        x0      = x0_v;
        iter    = iter_v;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (budget = 0; budget < 400 && !rootsFound; budget++) begin
            if (eval_req) begin
                held       = eval_x;
                eval_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick;
                    check("stall_req", 128'(eval_req), 128'(1'b1));
                    check("stall_x", 128'(eval_x), 128'(held));
                end
                stall      = 0;
                eval_ready = 1'b1;
                tick;
                eval_ready  = 1'b0;
                delta_valid = 1'b1;
                if (geo) begin
                    for (int c = 0; c < N; c++) eval_delta[c*DW +: DW] = 32'(4096 >> k);
                end else begin
                    eval_delta = d_v;
                end
                tick;
                delta_valid = 1'b0;
                eval_delta  = '0;
                k++;
                tick;
            end else begin
                tick;
            end
        end
        if (!rootsFound) check("timeout", 128'(rootsFound), 128'(1'b1));
        n_xfer = xfers - x_start;
    endtask

    initial begin
        int n;
        int rq0;
        rst         = 1'b1;
        start       = 1'b0;
        x0          = '0;
        iter        = '0;
        eval_ready  = 1'b0;
        delta_valid = 1'b0;
        eval_delta  = '0;
        tick;
        tick;
        check("rst_xn", 128'(xn), 128'(0));
        check("rst_iter", 128'(iterCount), 128'(0));
        check("rst_req", 128'(eval_req), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rf", 128'(rootsFound), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        rst = 1'b0;
        tick;

        // 1: nine constant steps of 0.25
        run_nr(X123, 4'd9, D25, 1'b0, 0, n);
        check("t1_xn", 128'(xn), 128'({32'h00C0_0000, 32'hFFC0_0000, 32'hFEC0_0000}));
        check("t1_iter", 128'(iterCount), 128'(9));
        check("t1_rf", 128'(rootsFound), 128'(1'b1));
        check("t1_busy", 128'(busy), 128'(0));
        check("t1_ovf", 128'(overflow), 128'(0));
        check("t1_xfers", 128'(n), 128'(9));

        // 2: geometric steps 4096>>k LSBs; cap of 15 is the maximum
        run_nr(X_ONES, 4'd15, '0, 1'b1, 0, n);
`ifdef NR_CONV_CHECK_EN
        check("t2_iter", 128'(iterCount), 128'(5));
        check("t2_xn", 128'(xn), 128'({3{32'h00FF_E100}}));
`else
        check("t2_iter", 128'(iterCount), 128'(15));
        check("t2_xn", 128'(xn), 128'({3{32'h00FF_E001}}));
`endif

        // 3: positive clamp on ch0, negative clamp on ch1
        run_nr({32'h0000_0000, 32'h8100_0000, 32'h7F00_0000}, 4'd1,
               {32'h0000_0000, 32'h0200_0000, 32'hFF00_0000}, 1'b0, 0, n);
        check("t3_xn", 128'(xn), 128'({32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF}));
        check("t3_ovf", 128'(overflow), 128'(1'b1));
        run_nr(X123, 4'd1, D25, 1'b0, 0, n);
        check("t3_ovf_clr", 128'(overflow), 128'(0));
        check("t3b_xn", 128'(xn), 128'({32'h02C0_0000, 32'h01C0_0000, 32'h00C0_0000}));

        // 4: zero cap
        rq0   = req_cycles;
        x0    = X123;
        iter  = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("t4_load_rf", 128'(rootsFound), 128'(0));
        check("t4_load_busy", 128'(busy), 128'(1'b1));
        tick;
        check("t4_rf", 128'(rootsFound), 128'(1'b1));
        check("t4_xn", 128'(xn), 128'(X123));
        check("t4_iter", 128'(iterCount), 128'(0));
        check("t4_noreq", 128'(req_cycles - rq0), 128'(0));

        // 5: five cycles of backpressure give the same result as the unstalled run
        run_nr(X123, 4'd1, D25, 1'b0, 5, n);
        check("t5_xfers", 128'(n), 128'(1));
        check("t5_xn", 128'(xn), 128'({32'h02C0_0000, 32'h01C0_0000, 32'h00C0_0000}));

        // 6: reset while waiting for the step, late delta ignored
        x0    = X123;
        iter  = 4'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int b = 0; b < 20 && !eval_req; b++) tick;
        check("t6_reach_req", 128'(eval_req), 128'(1'b1));
        eval_ready = 1'b1;
        tick;
        eval_ready = 1'b0;
        check("t6_wait_busy", 128'(busy), 128'(1'b1));
        rst         = 1'b1;
        delta_valid = 1'b1;
        eval_delta  = D25;
        #2;
        check("t6_async_xn", 128'(xn), 128'(0));
        tick;
        rst = 1'b0;
        tick;
        delta_valid = 1'b0;
        eval_delta  = '0;
        tick;
        check("t6_xn", 128'(xn), 128'(0));
        check("t6_evx", 128'(eval_x), 128'(0));
        check("t6_iter", 128'(iterCount), 128'(0));
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_rf", 128'(rootsFound), 128'(0));
        check("t6_req", 128'(eval_req), 128'(0));
        check("t6_ovf", 128'(overflow), 128'(0));
        run_nr(X123, 4'd8, D25, 1'b0, 0, n);
        check("t6r_iter", 128'(iterCount), 128'(8));
        check("t6r_rf", 128'(rootsFound), 128'(1'b1));
        check("t6r_xn", 128'(xn), 128'({32'h0100_0000, 32'h0000_0000, 32'hFF00_0000}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
